// File: rtl/sdram_rr_arbiter.sv
// Round-robin arbiter multiplexing NREQ requesters onto the single tsdram command port.
// One command is latched per grant and held until cmd_ack; read beats are steered to the last acked owner.
module sdram_rr_arbiter #(
  parameter int NREQ = 3,
  parameter int IDW  = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [2*NREQ-1:0]    req_i,
  input  logic [2*NREQ-1:0]    mask_i,
  input  logic [26*NREQ-1:0]   addr_i,
  input  logic [16*NREQ-1:0]   wdata_i,
  input  logic [NREQ-1:0]      lock_i,
  output logic [NREQ-1:0]      ack_o,
  output logic [NREQ-1:0]      dvalid_o,
  output logic [1:0]           cmd_req,
  output logic [1:0]           cmd_mask,
  output logic [25:0]          cmd_addr,
  output logic [15:0]          cmd_din,
  input  logic                 cmd_ack,
  input  logic                 data_valid,
  output logic [IDW-1:0]       owner_o,
  output logic                 busy_o
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_END} state_t;

  state_t           r_state, w_next;
  logic [IDW-1:0]   r_rr_ptr, r_owner, r_downer;
  logic [IDW-1:0]   w_win, w_win_inc, w_idx;
  logic             w_found;
  logic [NREQ-1:0]  w_pend, r_ack;
  logic [1:0]       w_code, w_mask;
  logic [25:0]      w_addr;
  logic [15:0]      w_wdata;
  logic [1:0]       r_cmd_req, r_cmd_mask;
  logic [25:0]      r_cmd_addr;
  logic [15:0]      r_cmd_din;

  // Reserved code 11 never counts as a request.
  always_comb begin
    w_pend = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_pend[i] = (req_i[2*i +: 2] == 2'b01) || (req_i[2*i +: 2] == 2'b10);
    end
  end

  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = r_rr_ptr;
    if (lock_i[r_owner] && w_pend[r_owner]) begin
      w_found = 1'b1;
      w_win   = r_owner;
    end else begin
      for (int k = 0; k < NREQ; k++) begin
        if (!w_found && w_pend[w_idx]) begin
          w_found = 1'b1;
          w_win   = w_idx;
        end
        w_idx = (w_idx == IDW'(NREQ-1)) ? '0 : w_idx + IDW'(1);
      end
    end
    w_win_inc = (w_win == IDW'(NREQ-1)) ? '0 : w_win + IDW'(1);
  end

  always_comb begin
    w_code  = '0;
    w_mask  = '0;
    w_addr  = '0;
    w_wdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_win == IDW'(i)) begin
        w_code  = req_i[2*i +: 2];
        w_mask  = mask_i[2*i +: 2];
        w_addr  = addr_i[26*i +: 26];
        w_wdata = wdata_i[16*i +: 16];
      end
    end
    // Line reads are burst-aligned on 8 words.
    if (w_code == 2'b10) w_addr[2:0] = 3'b000;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_found) w_next = S_WAIT;
      S_WAIT:  if (cmd_ack) w_next = S_END;
      S_END:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cmd_req  <= '0;
      r_cmd_mask <= '0;
      r_cmd_addr <= '0;
      r_cmd_din  <= '0;
      r_owner    <= '0;
      r_downer   <= '0;
      r_rr_ptr   <= '0;
      r_ack      <= '0;
    end else begin
      r_ack <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_cmd_req  <= w_code;
            r_cmd_mask <= w_mask;
            r_cmd_addr <= w_addr;
            r_cmd_din  <= w_wdata;
            r_owner    <= w_win;
            r_rr_ptr   <= w_win_inc;
          end
        end
        S_WAIT: begin
          if (cmd_ack) begin
            r_cmd_req <= 2'b00;
            r_ack     <= NREQ'(1) << r_owner;
            r_downer  <= r_owner;
          end
        end
        default: ;
      endcase
    end
  end

  // Read beats follow the owner of the most recently acked command.
  always_comb begin
    dvalid_o = '0;
    for (int i = 0; i < NREQ; i++) begin
      dvalid_o[i] = data_valid && (r_downer == IDW'(i));
    end
  end

  assign ack_o    = r_ack;
  assign cmd_req  = r_cmd_req;
  assign cmd_mask = r_cmd_mask;
  assign cmd_addr = r_cmd_addr;
  assign cmd_din  = r_cmd_din;
  assign owner_o  = r_owner;
  assign busy_o   = (r_state != S_IDLE);

endmodule

// File: tb/tb_sdram_rr_arbiter.sv
// Directed bench for sdram_rr_arbiter: reset, single write, rotation, lock, data steering, async reset.
module tb_sdram_rr_arbiter;
  localparam int NREQ = 3;
  localparam int IDW  = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic [5:0]        req_i, mask_i;
  logic [77:0]       addr_i;
  logic [47:0]       wdata_i;
  logic [2:0]        lock_i;
  logic [2:0]        ack_o, dvalid_o;
  logic [1:0]        cmd_req, cmd_mask;
  logic [25:0]       cmd_addr;
  logic [15:0]       cmd_din;
  logic              cmd_ack, data_valid;
  logic [1:0]        owner_o;
  logic              busy_o;

  int n_tests = 0;
  int n_fail  = 0;

  sdram_rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk(clk), .reset(reset), .req_i(req_i), .mask_i(mask_i), .addr_i(addr_i),
    .wdata_i(wdata_i), .lock_i(lock_i), .ack_o(ack_o), .dvalid_o(dvalid_o),
    .cmd_req(cmd_req), .cmd_mask(cmd_mask), .cmd_addr(cmd_addr), .cmd_din(cmd_din),
    .cmd_ack(cmd_ack), .data_valid(data_valid), .owner_o(owner_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1);
  end

  task automatic wait_busy(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (busy_o) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic pulse_ack(output logic [2:0] a);
    cmd_ack = 1'b1;
    @(negedge clk);
    cmd_ack = 1'b0;
    a = ack_o;
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    req_i = '0; mask_i = '0; addr_i = '0; wdata_i = '0; lock_i = '0;
    cmd_ack = 1'b0; data_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    req_i = '0; mask_i = '0; addr_i = '0; wdata_i = '0; lock_i = '0;
    cmd_ack = 1'b0; data_valid = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++;
    if (owner_o !== 2'd0) begin n_fail++; $display("FAIL reset_owner got=%h exp=0", owner_o); end
    reset = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      n_tests++;
      if ({cmd_req, ack_o, busy_o} !== 6'b0) begin
        n_fail++;
        $display("FAIL reset_idle cyc=%0d got req=%b ack=%b busy=%b exp all 0", c, cmd_req, ack_o, busy_o);
      end
    end
  endtask

  task automatic test_write();
    bit ok;
    logic [2:0] a;
    req_i = 6'b00_01_00; mask_i = 6'b00_11_00;
    addr_i[26 +: 26] = 26'h0001235; wdata_i[16 +: 16] = 16'hBEEF;
    wait_busy(ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL write_grant got busy=0 exp busy=1"); end
    n_tests++;
    if (cmd_req !== 2'b01) begin n_fail++; $display("FAIL write_code got=%b exp=01", cmd_req); end
    n_tests++;
    if (cmd_addr !== 26'h0001235) begin n_fail++; $display("FAIL write_addr got=%h exp=0001235", cmd_addr); end
    n_tests++;
    if (cmd_din !== 16'hBEEF) begin n_fail++; $display("FAIL write_din got=%h exp=beef", cmd_din); end
    n_tests++;
    if (cmd_mask !== 2'b11) begin n_fail++; $display("FAIL write_mask got=%b exp=11", cmd_mask); end
    n_tests++;
    if (owner_o !== 2'd1) begin n_fail++; $display("FAIL write_owner got=%0d exp=1", owner_o); end
    req_i = '0; addr_i = '0; wdata_i = '0;
    repeat (3) @(negedge clk);
    n_tests++;
    if (cmd_addr !== 26'h0001235 || cmd_req !== 2'b01 || !busy_o) begin
      n_fail++; $display("FAIL write_hold got addr=%h req=%b busy=%b exp 0001235/01/1", cmd_addr, cmd_req, busy_o);
    end
    pulse_ack(a);
    n_tests++;
    if (a !== 3'b010) begin n_fail++; $display("FAIL write_ack got=%b exp=010", a); end
    n_tests++;
    if (cmd_req !== 2'b00) begin n_fail++; $display("FAIL write_req_clear got=%b exp=00", cmd_req); end
    @(negedge clk);
    n_tests++;
    if (ack_o !== 3'b000 || busy_o !== 1'b0) begin
      n_fail++; $display("FAIL write_ack_len got ack=%b busy=%b exp 000/0", ack_o, busy_o);
    end
  endtask

  task automatic test_rotation();
    bit ok;
    logic [2:0] a;
    logic [1:0] exp_g [4];
    exp_g = '{2'd0, 2'd1, 2'd2, 2'd0};
    apply_reset();
    req_i = 6'b10_10_10;
    mask_i = 6'b11_11_11;
    addr_i = {26'h00000F7, 26'h00000F7, 26'h00000F7};
    for (int k = 0; k < 4; k++) begin
      wait_busy(ok);
      n_tests++;
      if (!ok) begin n_fail++; $display("FAIL rot_grant k=%0d got busy=0 exp busy=1", k); end
      n_tests++;
      if (owner_o !== exp_g[k]) begin n_fail++; $display("FAIL rot_owner k=%0d got=%0d exp=%0d", k, owner_o, exp_g[k]); end
      n_tests++;
      if (cmd_req !== 2'b10 || cmd_addr !== 26'h00000F0) begin
        n_fail++; $display("FAIL rot_cmd k=%0d got req=%b addr=%h exp 10/00000f0", k, cmd_req, cmd_addr);
      end
      pulse_ack(a);
      n_tests++;
      if (a !== (3'b001 << exp_g[k])) begin n_fail++; $display("FAIL rot_ack k=%0d got=%b exp=%b", k, a, 3'b001 << exp_g[k]); end
      if (k == 3) req_i = '0;
      @(negedge clk);
      n_tests++;
      if (ack_o !== 3'b000) begin n_fail++; $display("FAIL rot_ack_len k=%0d got=%b exp=000", k, ack_o); end
    end
  endtask

  task automatic test_lock();
    bit ok;
    logic [2:0] a;
    req_i = 6'b01_00_01;
    addr_i = {26'h0000200, 26'h0, 26'h0000100};
    lock_i = 3'b001;
    for (int k = 0; k < 3; k++) begin
      wait_busy(ok);
      n_tests++;
      if (!ok || owner_o !== 2'd0 || cmd_addr !== 26'h0000100) begin
        n_fail++; $display("FAIL lock_hold k=%0d got busy=%b owner=%0d addr=%h exp 1/0/0000100", k, busy_o, owner_o, cmd_addr);
      end
      pulse_ack(a);
      n_tests++;
      if (a !== 3'b001) begin n_fail++; $display("FAIL lock_ack k=%0d got=%b exp=001", k, a); end
      if (k == 2) lock_i = 3'b000;
    end
    wait_busy(ok);
    n_tests++;
    if (!ok || owner_o !== 2'd2 || cmd_addr !== 26'h0000200) begin
      n_fail++; $display("FAIL lock_release got busy=%b owner=%0d addr=%h exp 1/2/0000200", busy_o, owner_o, cmd_addr);
    end
    req_i = '0;
    pulse_ack(a);
    n_tests++;
    if (a !== 3'b100) begin n_fail++; $display("FAIL lock_release_ack got=%b exp=100", a); end
  endtask

  task automatic test_dvalid();
    bit ok;
    logic [2:0] a;
    logic [7:0] pat;
    pat = 8'b0100_1101;
    req_i = 6'b00_00_01;
    addr_i = {26'h0, 26'h0, 26'h0000300};
    wait_busy(ok);
    n_tests++;
    if (!ok || owner_o !== 2'd0) begin n_fail++; $display("FAIL dv_grant0 got busy=%b owner=%0d exp 1/0", busy_o, owner_o); end
    req_i = '0;
    pulse_ack(a);
    data_valid = 1'b1;
    #1;
    n_tests++;
    if (dvalid_o !== 3'b001) begin n_fail++; $display("FAIL dv_owner0 got=%b exp=001", dvalid_o); end
    data_valid = 1'b0;
    req_i = 6'b10_00_00;
    addr_i = {26'h00004F5, 26'h0, 26'h0};
    wait_busy(ok);
    n_tests++;
    if (!ok || owner_o !== 2'd2 || cmd_addr !== 26'h00004F0) begin
      n_fail++; $display("FAIL dv_grant2 got busy=%b owner=%0d addr=%h exp 1/2/00004f0", busy_o, owner_o, cmd_addr);
    end
    req_i = '0;
    data_valid = 1'b1;
    #1;
    n_tests++;
    if (dvalid_o !== 3'b001) begin n_fail++; $display("FAIL dv_before_ack got=%b exp=001", dvalid_o); end
    data_valid = 1'b0;
    pulse_ack(a);
    n_tests++;
    if (a !== 3'b100) begin n_fail++; $display("FAIL dv_ack got=%b exp=100", a); end
    for (int j = 0; j < 8; j++) begin
      data_valid = pat[j];
      #1;
      n_tests++;
      if (dvalid_o !== (pat[j] ? 3'b100 : 3'b000)) begin
        n_fail++; $display("FAIL dv_beat j=%0d got=%b exp=%b", j, dvalid_o, pat[j] ? 3'b100 : 3'b000);
      end
      @(negedge clk);
    end
    data_valid = 1'b0;
  endtask

  task automatic test_async_reset();
    bit ok;
    logic [2:0] a;
    req_i = 6'b00_01_00;
    addr_i = {26'h0, 26'h0000555, 26'h0};
    wdata_i = {16'h0, 16'h1234, 16'h0};
    wait_busy(ok);
    n_tests++;
    if (!ok || owner_o !== 2'd1) begin n_fail++; $display("FAIL ar_grant got busy=%b owner=%0d exp 1/1", busy_o, owner_o); end
    #2 reset = 1'b0;
    #1;
    n_tests++;
    if ({cmd_req, busy_o, ack_o, owner_o} !== 8'b0) begin
      n_fail++; $display("FAIL ar_ctrl got req=%b busy=%b ack=%b owner=%0d exp all 0", cmd_req, busy_o, ack_o, owner_o);
    end
    n_tests++;
    if ({cmd_addr, cmd_din, cmd_mask} !== 44'b0) begin
      n_fail++; $display("FAIL ar_data got addr=%h din=%h mask=%b exp 0", cmd_addr, cmd_din, cmd_mask);
    end
    cmd_ack = 1'b1;
    repeat (2) @(negedge clk);
    n_tests++;
    if (ack_o !== 3'b000) begin n_fail++; $display("FAIL ar_no_ack got=%b exp=000", ack_o); end
    cmd_ack = 1'b0;
    req_i = '0;
    reset = 1'b1;
    @(negedge clk);
    n_tests++;
    if (busy_o !== 1'b0 || ack_o !== 3'b000) begin
      n_fail++; $display("FAIL ar_release got busy=%b ack=%b exp 0/000", busy_o, ack_o);
    end
    req_i = 6'b01_01_00;
    addr_i = {26'h0000222, 26'h0000111, 26'h0};
    wait_busy(ok);
    n_tests++;
    if (!ok || owner_o !== 2'd1 || cmd_addr !== 26'h0000111) begin
      n_fail++; $display("FAIL ar_regrant got busy=%b owner=%0d addr=%h exp 1/1/0000111", busy_o, owner_o, cmd_addr);
    end
    req_i = '0;
    pulse_ack(a);
    n_tests++;
    if (a !== 3'b010) begin n_fail++; $display("FAIL ar_regrant_ack got=%b exp=010", a); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_rotation();
    test_lock();
    test_dvalid();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
